// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   localparam int WORD_CNT_W = 16;

   // A single-beat burst still needs a one-bit counter to keep the datapath legal.
   function automatic int beat_cnt_w(input int burst_len);
      return (burst_len <= 1) ? 1 : $clog2(burst_len);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping modulo NUM_REQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   // Walk last_idx+1 .. last_idx+NUM_REQ; the first hit is latched by valid.
   always_comb begin
      winner = {IDX_W{1'b0}};
      valid  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         winner = (req[(int'(last_idx) + k) % NUM_REQ] && !valid)
                  ? IDX_W'((int'(last_idx) + k) % NUM_REQ) : winner;
         valid  = valid | req[(int'(last_idx) + k) % NUM_REQ];
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_WORD_CNT_EN to build the per-requester accepted-word counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = 4
) (
   input  logic                           wr_clk,
   input  logic                           reset_l,
   input  logic                           arb_en,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy,
   input  logic                           full,
   output logic                           wr_en,
   output logic [DATA_WIDTH-1:0]          write_data,
   output logic [NUM_REQ*WORD_CNT_W-1:0]  word_cnt
);

   localparam int                 IDX_W     = $clog2(NUM_REQ);
   localparam int                 BEAT_W    = beat_cnt_w(BURST_LEN);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] GRANT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    last_grant_q, last_grant_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_vld_s;
   logic                owner_req_s;
   logic                wr_en_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req      (req),
      .last_idx (last_grant_q),
      .winner   (pick_idx_s),
      .valid    (pick_vld_s)
   );

   // last_grant doubles as the owner index while a burst is in progress.
   always_comb begin
      owner_req_s = req[last_grant_q];
      wr_en_s     = (state_q == ST_BURST) & owner_req_s & ~full;
   end

   assign wr_en      = wr_en_s;
   assign ack        = wr_en_s ? grant_q : {NUM_REQ{1'b0}};
   assign write_data = wr_en_s ? req_data[last_grant_q*DATA_WIDTH +: DATA_WIDTH]
                               : {DATA_WIDTH{1'b0}};
   assign grant      = grant_q;
   assign busy       = (state_q == ST_BURST);

   // Arbitration and burst sequencing.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_en && pick_vld_s) begin
               state_d      = ST_BURST;
               grant_d      = GRANT_ONE << pick_idx_s;
               last_grant_d = pick_idx_s;
               beat_cnt_d   = {BEAT_W{1'b0}};
            end else begin
               grant_d      = {NUM_REQ{1'b0}};
            end
         end
         ST_BURST: begin
            // A dropped request ends the burst even when full is also masking the write.
            if ((wr_en_s && (beat_cnt_q == LAST_BEAT)) || !owner_req_s) begin
               state_d    = ST_IDLE;
               grant_d    = {NUM_REQ{1'b0}};
               beat_cnt_d = {BEAT_W{1'b0}};
            end else if (wr_en_s) begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_d    = {NUM_REQ{1'b0}};
            beat_cnt_d = {BEAT_W{1'b0}};
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge wr_clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q      <= ST_IDLE;
         grant_q      <= {NUM_REQ{1'b0}};
         last_grant_q <= IDX_LAST;
         beat_cnt_q   <= {BEAT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_WORD_CNT_EN
   logic [NUM_REQ*WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

   // Saturating accepted-word counters, one per requester.
   always_comb begin
      word_cnt_d = word_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ack[i] && (word_cnt_q[i*WORD_CNT_W +: WORD_CNT_W] != {WORD_CNT_W{1'b1}})) begin
            word_cnt_d[i*WORD_CNT_W +: WORD_CNT_W] =
               word_cnt_q[i*WORD_CNT_W +: WORD_CNT_W] + WORD_CNT_W'(1);
         end else begin
            word_cnt_d[i*WORD_CNT_W +: WORD_CNT_W] = word_cnt_q[i*WORD_CNT_W +: WORD_CNT_W];
         end
      end
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge wr_clk or negedge reset_l) begin
      if (!reset_l) begin
         word_cnt_q <= {(NUM_REQ*WORD_CNT_W){1'b0}};
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;
`else
   assign word_cnt = {(NUM_REQ*WORD_CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers model queued words, expected FIFO writes are queued in order.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;

   logic                  wr_clk = 1'b0;
   logic                  reset_l;
   logic                  arb_en;
   logic                  full;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    ack;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  wr_en;
   logic [DW-1:0]         write_data;
   logic [NUM_REQ*16-1:0] word_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int src_wr[NUM_REQ];
   int src_rd[NUM_REQ];
   int ack_cnt[NUM_REQ];
   int wr_seen;
   logic [19:0] exp_q[$];

   logic [NUM_REQ-1:0] s_grant, s_ack;
   logic               s_busy, s_wr_en;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .wr_clk     (wr_clk),
      .reset_l    (reset_l),
      .arb_en     (arb_en),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .grant      (grant),
      .busy       (busy),
      .full       (full),
      .wr_en      (wr_en),
      .write_data (write_data),
      .word_cnt   (word_cnt)
   );

   function automatic logic [15:0] word_of(input int src, input int n);
      return {4'hA, 4'(src), 8'(n)};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = (src_rd[i] < src_wr[i]);
         req_data[i*DW +: DW] = req[i] ? word_of(i, src_rd[i]) : 16'h0000;
      end
   endtask

   task automatic load(input int src, input int n);
      src_wr[src] += n;
      drive_reqs();
   endtask

   task automatic exp_push(input int src, input int first, input int n);
      for (int k = first; k < first + n; k++) exp_q.push_back({4'(src), word_of(src, k)});
   endtask

   // One clock: sample outputs on the falling edge, score writes, then let producers consume acked words.
   task automatic step();
      logic [19:0] e;
      @(negedge wr_clk);
      s_grant = grant;
      s_ack   = ack;
      s_busy  = busy;
      s_wr_en = wr_en;
      if (wr_en) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            check_val("sb_extra_write", 64'(write_data), 64'h1_0000);
         end else begin
            e = exp_q.pop_front();
            check_val("write_data", 64'(write_data), 64'(e[15:0]));
            check_val("ack_owner", 64'(ack), 64'd1 << e[19:16]);
            ack_cnt[e[19:16]]++;
         end
      end else if (ack != 4'b0000) begin
         check_val("ack_without_wr", 64'(ack), 64'd0);
      end
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (s_ack[i]) src_rd[i]++;
      drive_reqs();
   endtask

   task automatic check_cnts(input string tag);
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FIFO_WR_ARB_WORD_CNT_EN
         check_val(tag, 64'(word_cnt[i*16 +: 16]), 64'(ack_cnt[i]));
`else
         check_val(tag, 64'(word_cnt[i*16 +: 16]), 64'd0);
`endif
      end
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      arb_en  = 1'b1;
      full    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src_wr[i]  = 0;
         src_rd[i]  = 0;
         ack_cnt[i] = 0;
      end
      exp_q.delete();
      wr_seen = 0;
      drive_reqs();
      repeat (2) @(posedge wr_clk);
      #1 reset_l = 1'b1;
   endtask

   initial begin
      logic [NUM_REQ-1:0] prev_g;
      int gi;

      // Reset values.
      do_reset();
      #2;
      check_val("rst_grant", 64'(grant), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_wr_en", 64'(wr_en), 64'd0);
      check_val("rst_ack", 64'(ack), 64'd0);
      check_val("rst_wdata", 64'(write_data), 64'd0);
      check_cnts("rst_word_cnt");

      // Single requester, 6 words: burst of 4, bubble, then 2.
      do_reset();
      load(0, 6);
      exp_push(0, 0, 6);
      step();
      check_val("t1_idle_busy", 64'(s_busy), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check_val("t1_grant", 64'(s_grant), 64'd1);
         check_val("t1_wr_en", 64'(s_wr_en), 64'd1);
      end
      step();
      check_val("t1_bubble_grant", 64'(s_grant), 64'd0);
      check_val("t1_bubble_wr", 64'(s_wr_en), 64'd0);
      step();
      step();
      check_val("t1_tail_grant", 64'(s_grant), 64'd1);
      step();
      check_val("t1_drop_wr", 64'(s_wr_en), 64'd0);
      step();
      check_val("t1_drained", 64'(exp_q.size()), 64'd0);
      check_cnts("t1_word_cnt");

      // All requesting: order 0,1,2,3,0 with a bubble before each burst.
      do_reset();
      load(0, 8);
      load(1, 4);
      load(2, 4);
      load(3, 4);
      exp_push(0, 0, 4);
      exp_push(1, 0, 4);
      exp_push(2, 0, 4);
      exp_push(3, 0, 4);
      exp_push(0, 4, 4);
      prev_g = '0;
      gi = 0;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c % 5 == 1) check_val("t2_bubble", 64'(s_busy), 64'd0);
         if (s_grant != 4'b0000 && prev_g == 4'b0000) begin
            check_val("t2_order", 64'(s_grant), 64'd1 << (gi % 4));
            gi++;
         end
         prev_g = s_grant;
      end
      check_val("t2_words_25cyc", 64'(wr_seen), 64'd20);
      check_val("t2_bursts", 64'(gi), 64'd5);
      step();
      check_val("t2_no_extra", 64'(wr_seen), 64'd20);
      check_cnts("t2_word_cnt");

      // Full for 3 cycles after 2 words: stall, then exactly 2 more words in this burst.
      do_reset();
      load(0, 6);
      exp_push(0, 0, 6);
      step();
      step();
      step();
      full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_val("t3_full_wr", 64'(s_wr_en), 64'd0);
         check_val("t3_full_ack", 64'(s_ack), 64'd0);
         check_val("t3_full_grant", 64'(s_grant), 64'd1);
      end
      full = 1'b0;
      step();
      check_val("t3_resume_wr", 64'(s_wr_en), 64'd1);
      step();
      check_val("t3_resume_wr", 64'(s_wr_en), 64'd1);
      step();
      check_val("t3_burst_end", 64'(s_grant), 64'd0);
      repeat (4) step();
      check_val("t3_drained", 64'(exp_q.size()), 64'd0);
      check_cnts("t3_word_cnt");

      // Requester 2 drops after 1 word; requester 3 follows after one IDLE cycle.
      do_reset();
      load(2, 1);
      load(3, 2);
      exp_push(2, 0, 1);
      exp_push(3, 0, 2);
      step();
      step();
      check_val("t4_grant2", 64'(s_grant), 64'd4);
      step();
      check_val("t4_drop_wr", 64'(s_wr_en), 64'd0);
      step();
      check_val("t4_idle", 64'(s_grant), 64'd0);
      step();
      check_val("t4_grant3", 64'(s_grant), 64'd8);
      repeat (3) step();
      check_val("t4_drained", 64'(exp_q.size()), 64'd0);

      // arb_en low during requester 1's burst: burst completes, then idle until re-enabled.
      do_reset();
      load(1, 8);
      exp_push(1, 0, 4);
      step();
      step();
      check_val("t5_grant1", 64'(s_grant), 64'd2);
      arb_en = 1'b0;
      load(0, 4);
      load(2, 4);
      load(3, 4);
      exp_push(2, 0, 4);
      exp_push(3, 0, 4);
      exp_push(0, 0, 4);
      exp_push(1, 4, 4);
      for (int k = 0; k < 3; k++) begin
         step();
         check_val("t5_finish_wr", 64'(s_wr_en), 64'd1);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         check_val("t5_off_grant", 64'(s_grant), 64'd0);
         check_val("t5_off_busy", 64'(s_busy), 64'd0);
      end
      arb_en = 1'b1;
      step();
      step();
      check_val("t5_reen_grant2", 64'(s_grant), 64'd4);
      repeat (40) step();
      check_val("t5_drained", 64'(exp_q.size()), 64'd0);
      check_cnts("t5_word_cnt");

      // Reset pulsed in the middle of requester 1's burst.
      do_reset();
      load(0, 8);
      load(1, 4);
      load(2, 4);
      load(3, 4);
      exp_push(0, 0, 4);
      exp_push(1, 0, 2);
      repeat (8) step();
      check_val("t6_pre_grant", 64'(grant), 64'd2);
      check_cnts("t6_pre_word_cnt");
      #2 reset_l = 1'b0;
      #1;
      check_val("t6_async_grant", 64'(grant), 64'd0);
      check_val("t6_async_ack", 64'(ack), 64'd0);
      check_val("t6_async_wr", 64'(wr_en), 64'd0);
      check_val("t6_async_busy", 64'(busy), 64'd0);
      for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
      check_cnts("t6_rst_word_cnt");
      exp_q.delete();
      exp_push(0, 4, 4);
      exp_push(1, 2, 2);
      exp_push(2, 0, 4);
      exp_push(3, 0, 4);
      @(posedge wr_clk);
      #3 reset_l = 1'b1;
      step();
      step();
      check_val("t6_first_grant0", 64'(s_grant), 64'd1);
      repeat (30) step();
      check_val("t6_drained", 64'(exp_q.size()), 64'd0);
      check_cnts("t6_word_cnt");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter for the asynchronous FIFO.
- Shares the FIFO write side (wr_en/write_data/full) between NUM_REQ requesters in the wr_clk domain.
- Grants bursts of up to BURST_LEN words per winner and stalls on full without dropping data.
- Sits between the write-side producers and the FIFO's write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, write data width; must match FIFO write_data
BURST_LEN, 4, max words written per grant (1..16)

Ports:
wr_clk  in  1  write-domain clock, sole clock
reset_l  in  1  asynchronous active-low reset
arb_en  in  1  1 = new grants allowed; 0 = finish current burst, then idle
req  in  NUM_REQ  per-requester request level, bit i = requester i
req_data  in  NUM_REQ*DATA_WIDTH  flattened data, slice i = requester i
ack  out  NUM_REQ  one-hot; word from requester i accepted this cycle
grant  out  NUM_REQ  registered one-hot current owner, 0 when idle
busy  out  1  1 when state = BURST
full  in  1  FIFO full flag (wr_clk-domain level)
wr_en  out  1  FIFO write enable
write_data  out  DATA_WIDTH  FIFO write data
word_cnt  out  NUM_REQ*16  per-requester accepted-word counters (see Optional Feature)

Behaviour:
- Reset (reset_l low, async): state=IDLE, grant=0, beat_cnt=0, last_grant=NUM_REQ-1 so requester 0 wins first; ack=0, wr_en=0, busy=0, write_data=0.
- State IDLE:
  - If arb_en=1 and req!=0, pick the first set req bit searching last_grant+1, +2, ... modulo NUM_REQ.
  - Next edge: grant=onehot(winner), last_grant=winner, beat_cnt=0, state=BURST.
  - Otherwise stay in IDLE.
- State BURST, owner g:
  - wr_en = req[g] & ~full (combinational from the registered grant).
  - write_data = req_data slice g while wr_en=1, else 0.
  - ack[g] = wr_en; all other ack bits 0.
  - On wr_en: beat_cnt++.
  - Exit to IDLE (grant=0) on the edge where (wr_en and beat_cnt==BURST_LEN-1) or req[g]==0.
  - Otherwise hold state.
- Latency:
  - First write is no earlier than 1 cycle after req rises in IDLE.
  - Each burst is followed by exactly 1 IDLE cycle: re-arbitration bubble, no back-to-back grants.
- Full:
  - full=1 in BURST: wr_en=0, ack=0, beat_cnt and grant held.
  - Resumes the cycle full drops. No word lost or duplicated.
- Requester contract:
  - A requester holds its data stable until ack.
  - Dropping req while granted ends the burst; the next cycle is IDLE.
- arb_en:
  - Sampled only in IDLE.
  - Deassertion mid-burst has no effect until the burst ends.
- Fairness:
  - With all requesters continuously requesting, grant order is 0,1,2,...,NUM_REQ-1,0.
  - Each burst is exactly BURST_LEN words unless full or a req drop intervenes.
- Simultaneous events:
  - If req[g] drops and full is high in the same cycle, exit to IDLE with no write.
  - If the last beat is written while other requests are pending, IDLE next cycle, then the rotated winner.
- Reset mid-burst: immediate return to IDLE, counters cleared, no partial state retained.

Optional Feature:
- Macro: FIFO_WR_ARB_WORD_CNT_EN.
- Defined:
  - One 16-bit counter per requester; word_cnt slice i increments on ack[i].
  - Counters saturate at 16'hFFFF.
  - Cleared by reset only.
- Undefined:
  - No counter registers are built.
  - word_cnt is tied to 0; port list is unchanged.

Decomposition:
- Package fifo_arb_pkg:
  - State encoding (IDLE=1'b0, BURST=1'b1).
  - Counter width constant WORD_CNT_W=16.
  - beat_cnt width rule: clog2(BURST_LEN) with a minimum of 1.
- Sub-module rr_pick: combinational round-robin picker. Inputs req and last_grant index; outputs winner index and valid. Reused by the planned read-side scheduler.

Test Plan:
- Single requester: req=4'b0001 with 6 words queued, BURST_LEN=4, full=0 -> ack0 on 4 consecutive cycles, 1 IDLE cycle, then 2 more words; FIFO holds 6 words in order.
- All req=4'b1111 continuously -> grant sequence 0,1,2,3,0, each burst 4 writes, 1 bubble cycle between bursts; 20 words in 25 cycles.
- full forced high for 3 cycles mid-burst after 2 words -> wr_en/ack low those 3 cycles, beat_cnt stays 2, then exactly 2 more words; no duplicate data.
- Requester 2 drops req after 1 word -> next cycle IDLE; requester 3 granted on the following edge (rotation from last_grant=2).
- arb_en=0 during requester 1's burst -> burst completes (4 words), then grant=0 and busy=0 indefinitely despite req=4'b1111; re-enable -> requester 2 granted.
- reset_l pulsed low mid-burst -> grant, ack, wr_en drop to 0 asynchronously; after release requester 0 wins first. With FIFO_WR_ARB_WORD_CNT_EN, counters read 0 after reset and equal each requester's ack count otherwise.
